// File: rtl/idma_txrx_rx_packer_if.sv
// Handshake bundle between the txrx byte receiver, the rx packer and the transport-layer read port.
// The master side drives bytes in and consumes words out; the packer sits on the slave side.
interface idma_txrx_rx_packer_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 4
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned LvlWidth  = $clog2(FifoDepth + 1);

  logic [7:0]           rx_byte_i;
  logic                 rx_last_i;
  logic                 rx_valid_i;
  logic                 rx_ready_o;
  logic                 flush_i;
  logic [DataWidth-1:0] data_o;
  logic [StrbWidth-1:0] strb_o;
  logic                 last_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [LvlWidth-1:0]  level_o;
  logic                 busy_o;

  modport master (
    output rx_byte_i, rx_last_i, rx_valid_i, flush_i, ready_i,
    input  rx_ready_o, data_o, strb_o, last_o, valid_o, level_o, busy_o
  );

  modport slave (
    input  rx_byte_i, rx_last_i, rx_valid_i, flush_i, ready_i,
    output rx_ready_o, data_o, strb_o, last_o, valid_o, level_o, busy_o
  );
endinterface

// File: rtl/idma_txrx_rx_packer.sv
// Packs received bytes little-endian into DataWidth words (closed on a full word or frame end)
// and queues them in a small FIFO toward the transport-layer read port.
module idma_txrx_rx_packer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 4
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  idma_txrx_rx_packer_if.slave  bus
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned LvlWidth  = $clog2(FifoDepth + 1);
  localparam int unsigned CntWidth  = $clog2(StrbWidth);
  localparam int unsigned PtrWidth  = $clog2(FifoDepth);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } word_t;

  word_t                mem [FifoDepth];
  logic [CntWidth-1:0]  cnt;
  logic [DataWidth-1:0] partial;
  logic [PtrWidth-1:0]  wptr;
  logic [PtrWidth-1:0]  rptr;
  logic [LvlWidth-1:0]  level;

  logic  full;
  logic  empty;
  logic  accept;
  logic  close_word;
  logic  push;
  logic  pop;
  word_t push_word;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at the registered level: a pop on this edge never frees a slot early.
  assign full          = (level == LvlWidth'(FifoDepth));
  assign empty         = (level == '0);
  assign bus.rx_ready_o = !full && !bus.flush_i;
  assign accept        = bus.rx_valid_i && bus.rx_ready_o;
  assign close_word    = (cnt == CntWidth'(StrbWidth - 1)) || bus.rx_last_i;
  assign push          = accept && close_word;
  assign pop           = !empty && bus.ready_i && !bus.flush_i;

  // Assemble the closing word: lanes below the counter come from the partial register,
  // the counter's lane takes the incoming byte, and higher lanes stay zero.
  always_comb begin
    // NOTE: defaulting every field first keeps this block purely combinational (no latches).
    push_word      = '0;
    push_word.last = bus.rx_last_i;
    for (int i = 0; i < StrbWidth; i++) begin
      if (CntWidth'(i) == cnt) begin
        push_word.data[8*i +: 8] = bus.rx_byte_i;
        push_word.strb[i]        = 1'b1;
      end else if (CntWidth'(i) < cnt) begin
        push_word.data[8*i +: 8] = partial[8*i +: 8];
        push_word.strb[i]        = 1'b1;
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= '0;
      partial <= '0;
    end else if (bus.flush_i) begin
      cnt     <= '0;
      partial <= '0;
    end else if (accept) begin
      if (close_word) begin
        cnt     <= '0;
        partial <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        for (int i = 0; i < StrbWidth; i++) begin
          if (CntWidth'(i) == cnt) partial[8*i +: 8] <= bus.rx_byte_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (bus.flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible because outputs are gated by valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= push_word;
  end

  assign bus.valid_o = !empty;
  assign bus.data_o  = bus.valid_o ? mem[rptr].data : '0;
  assign bus.strb_o  = bus.valid_o ? mem[rptr].strb : '0;
  assign bus.last_o  = bus.valid_o ? mem[rptr].last : 1'b0;
  assign bus.level_o = level;
  assign bus.busy_o  = !empty || (cnt != '0);
endmodule

// File: tb/tb_idma_txrx_rx_packer.sv
// Self-checking bench for idma_txrx_rx_packer: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based model of the packing rules.
module tb_idma_txrx_rx_packer;
  localparam int unsigned DW = 32;
  localparam int unsigned FD = 4;
  localparam int unsigned SW = DW / 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  idma_txrx_rx_packer_if #(.DataWidth(DW), .FifoDepth(FD)) bus ();

  idma_txrx_rx_packer #(.DataWidth(DW), .FifoDepth(FD)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0]  b;
    logic        l, v, r, f;
    logic        rdy, vld;
    logic [31:0] d;
    logic [3:0]  s;
    logic        lst;
    logic [2:0]  lvl;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } mword_t;

  vec_t       vecs[$];
  mword_t     mq[$];
  logic [7:0] pb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic vld, input logic [31:0] d,
                            input logic [3:0] s, input logic lst, input logic [2:0] lvl, input logic busy);
    check({tag, ".rx_ready"}, 64'(bus.rx_ready_o), 64'(rdy));
    check({tag, ".valid"},    64'(bus.valid_o),    64'(vld));
    check({tag, ".data"},     64'(bus.data_o),     64'(d));
    check({tag, ".strb"},     64'(bus.strb_o),     64'(s));
    check({tag, ".last"},     64'(bus.last_o),     64'(lst));
    check({tag, ".level"},    64'(bus.level_o),    64'(lvl));
    check({tag, ".busy"},     64'(bus.busy_o),     64'(busy));
  endtask

  // Present one cycle of inputs, let the edge happen, then idle the byte/flush inputs before sampling.
  task automatic drive(input logic [7:0] b, input logic l, input logic v, input logic r, input logic f);
    @(negedge clk_i);
    bus.rx_byte_i  = b;
    bus.rx_last_i  = l;
    bus.rx_valid_i = v;
    bus.ready_i    = r;
    bus.flush_i    = f;
    @(posedge clk_i);
    #1;
    bus.rx_valid_i = 1'b0;
    bus.rx_last_i  = 1'b0;
    bus.flush_i    = 1'b0;
    #1;
  endtask

  initial begin
    rst_ni         = 1'b0;
    bus.rx_byte_i  = '0;
    bus.rx_last_i  = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.ready_i    = 1'b0;
    bus.flush_i    = 1'b0;
    #1;
    check_outs("reset", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // b, l, v, r, f | rdy, vld, data, strb, last, level, busy
    vecs.push_back('{8'h11, 0, 1, 1, 0, 1, 0, 32'h0,        4'h0, 0, 3'd0, 1});
    vecs.push_back('{8'h22, 0, 1, 1, 0, 1, 0, 32'h0,        4'h0, 0, 3'd0, 1});
    vecs.push_back('{8'h33, 0, 1, 1, 0, 1, 0, 32'h0,        4'h0, 0, 3'd0, 1});
    vecs.push_back('{8'h44, 0, 1, 1, 0, 1, 1, 32'h44332211, 4'hF, 0, 3'd1, 1});
    vecs.push_back('{8'h00, 0, 0, 1, 0, 1, 0, 32'h0,        4'h0, 0, 3'd0, 0});
    vecs.push_back('{8'hAA, 0, 1, 0, 0, 1, 0, 32'h0,        4'h0, 0, 3'd0, 1});
    vecs.push_back('{8'hBB, 1, 1, 0, 0, 1, 1, 32'h0000BBAA, 4'h3, 1, 3'd1, 1});
    vecs.push_back('{8'h00, 0, 0, 0, 0, 1, 1, 32'h0000BBAA, 4'h3, 1, 3'd1, 1});
    vecs.push_back('{8'h00, 0, 0, 1, 0, 1, 0, 32'h0,        4'h0, 0, 3'd0, 0});
    vecs.push_back('{8'h01, 0, 1, 0, 0, 1, 0, 32'h0,        4'h0, 0, 3'd0, 1});
    vecs.push_back('{8'h02, 0, 1, 0, 0, 1, 0, 32'h0,        4'h0, 0, 3'd0, 1});
    vecs.push_back('{8'h03, 0, 1, 0, 1, 1, 0, 32'h0,        4'h0, 0, 3'd0, 0});
    vecs.push_back('{8'h04, 1, 1, 0, 0, 1, 1, 32'h00000004, 4'h1, 1, 3'd1, 1});
    vecs.push_back('{8'h00, 0, 0, 1, 0, 1, 0, 32'h0,        4'h0, 0, 3'd0, 0});
    vecs.push_back('{8'h55, 1, 1, 0, 0, 1, 1, 32'h00000055, 4'h1, 1, 3'd1, 1});
    vecs.push_back('{8'h00, 0, 0, 0, 1, 1, 0, 32'h0,        4'h0, 0, 3'd0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].b, vecs[i].l, vecs[i].v, vecs[i].r, vecs[i].f);
      check_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].vld, vecs[i].d, vecs[i].s,
                 vecs[i].lst, vecs[i].lvl, vecs[i].busy);
    end

    // Backpressure: fill the FIFO, show no pop bypass on ready, then drain in order.
    for (int i = 0; i < 16; i++) drive(8'(i + 1), 0, 1, 0, 0);
    check_outs("bp_full", 0, 1, 32'h04030201, 4'hF, 0, 3'd4, 1);
    drive(8'h99, 0, 1, 1, 0);
    check_outs("bp_pop1", 1, 1, 32'h08070605, 4'hF, 0, 3'd3, 1);
    drive(8'h00, 0, 0, 1, 0);
    check_outs("bp_pop2", 1, 1, 32'h0C0B0A09, 4'hF, 0, 3'd2, 1);
    drive(8'h00, 0, 0, 1, 0);
    check_outs("bp_pop3", 1, 1, 32'h100F0E0D, 4'hF, 0, 3'd1, 1);
    drive(8'h00, 0, 0, 1, 0);
    check_outs("bp_empty", 1, 0, 32'h0, 4'h0, 0, 3'd0, 0);

    // Simultaneous push and pop at level 2.
    for (int i = 0; i < 11; i++) drive(8'(8'h21 + i), 0, 1, 0, 0);
    check_outs("pp_pre", 1, 1, 32'h24232221, 4'hF, 0, 3'd2, 1);
    drive(8'h2C, 0, 1, 1, 0);
    check_outs("pp_same", 1, 1, 32'h28272625, 4'hF, 0, 3'd2, 1);
    drive(8'h00, 0, 0, 1, 0);
    check_outs("pp_next", 1, 1, 32'h2C2B2A29, 4'hF, 0, 3'd1, 1);
    drive(8'h00, 0, 0, 1, 0);
    check_outs("pp_empty", 1, 0, 32'h0, 4'h0, 0, 3'd0, 0);

    // Reset mid-frame with three queued words and two pending bytes.
    for (int i = 0; i < 14; i++) drive(8'(8'h31 + i), 0, 1, 0, 0);
    check_outs("rst_pre", 1, 1, 32'h34333231, 4'hF, 0, 3'd3, 1);
    #1;
    rst_ni = 1'b0;
    #1;
    check_outs("rst_async", 1, 0, 32'h0, 4'h0, 0, 3'd0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(8'h77, 1, 1, 0, 0);
    check_outs("rst_lane0", 1, 1, 32'h00000077, 4'h1, 1, 3'd1, 1);

    // Random traffic against the model, starting from a flushed state.
    drive(8'h00, 0, 0, 0, 1);
    mq.delete();
    pb.delete();
    for (int n = 0; n < 400; n++) begin
      logic [7:0]  b;
      logic        l, v, r, f, rdy_m;
      logic [31:0] d;
      mword_t      w;
      b = 8'($urandom);
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 1) == 1);
      f = ($urandom_range(0, 39) == 0);
      rdy_m = (mq.size() < FD) && !f;
      drive(b, l, v, r, f);
      if (f) begin
        mq.delete();
        pb.delete();
      end else begin
        if (mq.size() > 0 && r) void'(mq.pop_front());
        if (v && rdy_m) begin
          pb.push_back(b);
          if (pb.size() == SW || l) begin
            d = '0;
            for (int k = 0; k < pb.size(); k++) d = d | (32'(pb[k]) << (8 * k));
            w.d = d;
            w.s = 4'((1 << pb.size()) - 1);
            w.l = l;
            mq.push_back(w);
            pb.delete();
          end
        end
      end
      if (mq.size() > 0)
        check_outs($sformatf("rnd%0d", n), mq.size() < FD, 1, mq[0].d, mq[0].s, mq[0].l,
                   3'(mq.size()), 1);
      else
        check_outs($sformatf("rnd%0d", n), 1, 0, 32'h0, 4'h0, 0, 3'd0, pb.size() != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/idma_txrx_rx_packer.md
IDMA_TXRX_RX_PACKER -- requirements
Module: idma_txrx_rx_packer

Interface
REQ-001 SHALL have parameter DataWidth, default 32, output word width in bits; legal values are multiples of 8, minimum 16.
REQ-002 SHALL have parameter FifoDepth, default 4, number of packed words the output FIFO holds; minimum 2.
REQ-003 SHALL use derived constant StrbWidth = DataWidth/8.
REQ-004 SHALL use derived constant LvlWidth = $clog2(FifoDepth+1).
REQ-005 SHALL have one clock and an asynchronous, active-low reset; the ports are clk_i and rst_ni.
REQ-006 SHALL have the following ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- rx_byte_i  in  8  incoming byte from the txrx receiver.
- rx_last_i  in  1  qualifies rx_byte_i as the final byte of a frame.
- rx_valid_i  in  1  byte valid.
- rx_ready_o  out  1  byte ready.
- flush_i  in  1  synchronous clear of all packing and FIFO state.
- data_o  out  DataWidth  packed word toward the transport-layer read port.
- strb_o  out  StrbWidth  byte-valid mask of data_o.
- last_o  out  1  word closes a frame.
- valid_o  out  1  word valid.
- ready_i  in  1  word ready.
- level_o  out  LvlWidth  current FIFO occupancy.
- busy_o  out  1  block holds unsent data.

Function
REQ-007 SHALL accept a byte on a rising edge where rx_valid_i and rx_ready_o are both high.
REQ-008 SHALL drive rx_ready_o = (level_o != FifoDepth) AND NOT flush_i, with no same-cycle pop bypass.
REQ-009 SHALL place accepted bytes little-endian: the byte at byte-counter value k goes to lane k (bits 8k+7:8k).
REQ-010 SHALL keep a byte counter of width $clog2(StrbWidth), reset to 0, incremented per accepted byte.
REQ-011 SHALL close a word when the accepted byte fills lane StrbWidth-1 or carries rx_last_i; on that same edge the counter returns to 0.
REQ-012 SHALL push a closed word into the FIFO on the accepting edge with:
- strb = lanes 0..k set, where k is the lane of the closing byte;
- unfilled lanes of data forced to 0;
- last = rx_last_i of the closing byte.
REQ-013 SHALL assert valid_o in the cycle after the push edge when the FIFO was empty, giving one cycle of latency from the closing byte to valid_o.
REQ-014 SHALL drive data_o, strb_o and last_o from the FIFO head, held stable while valid_o is high and ready_i is low.
REQ-015 SHALL drive data_o, strb_o and last_o to 0 whenever valid_o is low.
REQ-016 SHALL pop the FIFO head on an edge where valid_o and ready_i are both high.
REQ-017 SHALL, on a simultaneous push and pop, leave level_o unchanged and preserve FIFO ordering.
REQ-018 SHALL wrap the FIFO read and write pointers modulo FifoDepth.
REQ-019 SHALL make level_o exact at every cycle, ranging 0..FifoDepth.
REQ-020 SHALL treat flush_i high at an edge as follows, taking priority over any push or pop on that edge:
- clear the byte counter, partial word, FIFO pointers and level;
- accept no byte and pop no word on that edge.
REQ-021 SHALL drive busy_o = (level_o != 0) OR (byte counter != 0).
REQ-022 SHALL drive valid_o from FIFO occupancy only, never depending on ready_i.
REQ-023 SHALL keep a word that was presented on valid_o and not yet popped in the FIFO, unchanged, until popped or flushed.

Reset
REQ-024 SHALL, while rst_ni is low, asynchronously clear the byte counter, partial word, FIFO pointers and level.
REQ-025 SHALL hold outputs during reset at: rx_ready_o=1, valid_o=0, data_o=0, strb_o=0, last_o=0, level_o=0, busy_o=0.
REQ-026 SHALL, on reset assertion mid-frame, discard all partial and queued data; after release, the first accepted byte lands in lane 0.

Verification
REQ-027 SHALL pass: full word. Bytes 0x11,0x22,0x33,0x44 streamed back-to-back, ready_i=1 -> one cycle after the 4th byte: valid_o=1, data_o=0x44332211, strb_o=0xF, last_o=0.
REQ-028 SHALL pass: partial last. Bytes 0xAA, then 0xBB with rx_last_i=1 -> data_o=0x0000BBAA, strb_o=0x3, last_o=1; busy_o=0 after the pop.
REQ-029 SHALL pass: backpressure. ready_i=0, 16 bytes offered (FifoDepth=4) -> level_o reaches 4 and rx_ready_o=0 after the 16th byte; one pop then raises rx_ready_o the next cycle, with words in order.
REQ-030 SHALL pass: simultaneous push and pop. level_o=2 with ready_i=1 while a closing byte is accepted -> level_o stays 2 and output order is preserved.
REQ-031 SHALL pass: flush mid-word. Two bytes accepted, flush_i pulsed with rx_valid_i=1 -> that byte is not accepted, level_o=0, busy_o=0; the next byte lands in lane 0.
REQ-032 SHALL pass: reset mid-frame. Assert rst_ni=0 with level_o=3 and the counter at 2 -> all outputs at the REQ-025 values immediately, with no clock edge required.
